// File: rtl/bin_to_bcd_encoder.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_encoder
//   Sequential binary-to-BCD encoder using shift-and-add-3 (double dabble),
//   one input bit per clock, MSB first. Drives the packed 4-bit BCD digit bus
//   of the seven-segment decoders; code 4'hF is the blank code.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   start     in   conversion request, sampled only in IDLE
//   bin       in   unsigned value [IN_WIDTH-1:0], captured on accept
//   blank_lz  in   1 = blank leading zeros, captured with bin
//   busy      out  conversion in progress
//   done      out  one-cycle pulse when bcd/overflow are updated
//   overflow  out  last result exceeded 10^DIGITS-1
//   bcd       out  digit i at [4i+3:4i], digit 0 least significant
// -----------------------------------------------------------------------------
module bin_to_bcd_encoder #(
  parameter int unsigned IN_WIDTH = 14,
  parameter int unsigned DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd
);

  // Number of decimal digits needed for 2^w - 1.
  function automatic int unsigned f_dec_digits(input int unsigned w);
    logic [63:0]  v;
    int unsigned  n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    while (v != 64'd0) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return (n == 0) ? 1 : n;
  endfunction

  function automatic logic [63:0] f_pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam int unsigned ACC_DIGITS = f_dec_digits(IN_WIDTH);
  // Accumulator is never narrower than the output so the low DIGITS
  // digits can always be sliced directly.
  localparam int unsigned ACC_N      = (ACC_DIGITS > DIGITS) ? ACC_DIGITS : DIGITS;
  localparam int unsigned ACC_W      = 4 * ACC_N;
  localparam logic [63:0] MAX_VAL    = f_pow10(DIGITS) - 64'd1;
  localparam int unsigned CNT_W      = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_FINISH  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  logic [IN_WIDTH-1:0]     r_bin;
  logic [IN_WIDTH-1:0]     r_shift;
  logic                    r_blank;
  logic [ACC_W-1:0]        r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_ovf;
  logic [4*DIGITS-1:0]     r_bcd;

  logic [ACC_W-1:0]          w_acc_adj;
  logic [ACC_W+IN_WIDTH-1:0] w_shifted;
  logic [4*DIGITS-1:0]       w_result;
  logic                      w_ovf;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next_state = S_CONVERT;
      S_CONVERT: if (r_cnt == LAST_CNT) w_next_state = S_FINISH;
      S_FINISH:  w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Add-3 correction on every nibble >= 5, then one-bit shift of the
  // combined {accumulator, shift register}.
  always_comb begin
    w_acc_adj = r_acc;
    for (int unsigned i = 0; i < ACC_N; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
  end

  assign w_shifted = {w_acc_adj, r_shift} << 1;

  // Post-processing: overflow substitution and leading-zero blanking,
  // scanning from the most significant digit down to digit 1.
  always_comb begin
    logic v_seen;
    v_seen   = 1'b0;
    w_ovf    = (64'(r_bin) > MAX_VAL);
    w_result = r_acc[4*DIGITS-1:0];
    if (w_ovf) begin
      w_result = '1;
    end else if (r_blank) begin
      for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
        if (w_result[4*(DIGITS-1-k) +: 4] != 4'h0) v_seen = 1'b1;
        else if (!v_seen) w_result[4*(DIGITS-1-k) +: 4] = 4'hF;
      end
    end
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin   <= '0;
      r_shift <= '0;
      r_blank <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_bcd   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin   <= bin;
            r_shift <= bin;
            r_blank <= blank_lz;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CONVERT: begin
          r_acc   <= w_shifted[ACC_W+IN_WIDTH-1:IN_WIDTH];
          r_shift <= w_shifted[IN_WIDTH-1:0];
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        S_FINISH: begin
          r_bcd  <= w_result;
          r_ovf  <= w_ovf;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf;
  assign bcd      = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_encoder.sv
module tb_bin_to_bcd_encoder;

  localparam int unsigned IN_WIDTH = 14;
  localparam int unsigned DIGITS   = 4;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [IN_WIDTH-1:0]  bin;
  logic                 blank_lz;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic [4*DIGITS-1:0]  bcd;

  int checks;
  int failures;

  logic [15:0] last_bcd;
  logic        last_ovf;

  bin_to_bcd_encoder #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin), .blank_lz(blank_lz),
    .busy(busy), .done(done), .overflow(overflow), .bcd(bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, then display rules.
  function automatic void model(input int unsigned v, input bit blz,
                                output logic [15:0] b, output logic o);
    int unsigned d [DIGITS];
    bit seen;
    int unsigned t;
    o = (v > 9999);
    b = '0;
    if (o) begin
      b = 16'hFFFF;
      return;
    end
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = t % 10;
      t = t / 10;
    end
    seen = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (d[i] != 0) seen = 1;
      if (blz && !seen && i > 0) b[4*i +: 4] = 4'hF;
      else b[4*i +: 4] = d[i][3:0];
    end
  endfunction

  // One conversion; samples at the negedge after each edge En (k = n).
  task automatic run_conv(input int unsigned v, input bit blz, input bit poke);
    logic [15:0] eb;
    logic        eo;
    int busy_cnt, done_cnt, done_k;
    @(negedge clk);
    start = 1'b1; bin = IN_WIDTH'(v); blank_lz = blz;
    @(posedge clk);
    busy_cnt = 0; done_cnt = 0; done_k = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        bin = IN_WIDTH'($urandom);
        blank_lz = ~blz;
      end
      if (poke && k == 3) begin start = 1'b1; bin = IN_WIDTH'(5555); end
      if (poke && k == 4) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_k = k; end
      if (k == 6) begin
        chk("hold_bcd", 32'(bcd), 32'(last_bcd));
        chk("hold_ovf", 32'(overflow), 32'(last_ovf));
      end
    end
    model(v, blz, eb, eo);
    chk("busy_cycles", busy_cnt, 15);
    chk("done_count", done_cnt, 1);
    chk("done_latency", done_k, 15);
    chk("bcd", 32'(bcd), 32'(eb));
    chk("overflow", 32'(overflow), 32'(eo));
    last_bcd = eb;
    last_ovf = eo;
  endtask

  initial begin
    int done_times [$];
    int cyc;
    checks = 0; failures = 0;
    reset = 1'b0; start = 1'b0; bin = '0; blank_lz = 1'b0;
    last_bcd = 16'h0000; last_ovf = 1'b0;

    // Asynchronous reset between edges
    #7 reset = 1'b1;
    #1;
    chk("rst_bcd", 32'(bcd), 32'h0000);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Directed values
    run_conv(1234, 0, 0);
    run_conv(42, 1, 0);
    run_conv(0, 1, 0);
    run_conv(1005, 1, 0);
    run_conv(9999, 0, 0);
    run_conv(10000, 0, 0);
    run_conv(16383, 1, 0);
    run_conv(0, 0, 0);
    run_conv(7, 0, 1);    // start pulse with 5555 during busy is ignored

    // start held high: back-to-back conversions every IN_WIDTH+2 cycles
    @(negedge clk);
    start = 1'b1; bin = IN_WIDTH'(7); blank_lz = 1'b0;
    for (cyc = 0; cyc < 70; cyc++) begin
      @(negedge clk);
      if (done) done_times.push_back(cyc);
    end
    start = 1'b0;
    chk("held_done_count", done_times.size(), 4);
    for (int i = 1; i < done_times.size(); i++)
      chk("held_period", done_times[i] - done_times[i-1], 16);
    chk("held_bcd", 32'(bcd), 32'h0007);
    for (int i = 0; i < 20; i++) @(negedge clk);
    chk("held_idle", 32'(busy), 0);

    // Reset during the 7th CONVERT cycle aborts without done
    @(negedge clk);
    start = 1'b1; bin = IN_WIDTH'(321); blank_lz = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("abort_bcd", 32'(bcd), 32'h0000);
    chk("abort_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int dn;
      dn = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done) dn++;
      end
      chk("abort_no_done", dn, 0);
    end
    last_bcd = 16'h0000; last_ovf = 1'b0;
    run_conv(8, 0, 0);
    chk("after_abort", 32'(bcd), 32'h0008);

    // Randomized values, biased around the overflow boundary
    for (int n = 0; n < 20; n++) begin
      int unsigned v;
      if (n % 4 == 0) v = $urandom_range(10005, 9995);
      else v = $urandom_range(16383, 0);
      run_conv(v, 1'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
